// File: rtl/mips_decode_pkg.sv
// Shared decode constants for the MIPS decode + ALU stage: opcode/funct
// encodings, ALUOp and ALUCtl enumerations, and the control-vector layout.
// Imported by mips_alu_core and mips_decode_alu_stage.
package mips_decode_pkg;

  // Primary opcodes, instr[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  // R-type function codes, instr[5:0]
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;

  // Main-decode to ALU-control class
  typedef enum logic [2:0] {
    ALUOP_ADD   = 3'b000,
    ALUOP_SUB   = 3'b001,
    ALUOP_RTYPE = 3'b010,
    ALUOP_AND   = 3'b011,
    ALUOP_OR    = 3'b100,
    ALUOP_SLT   = 3'b101,
    ALUOP_ZERO  = 3'b110,
    ALUOP_LUI   = 3'b111
  } alu_op_e;

  // ALU operation select
  typedef enum logic [3:0] {
    ALUCTL_AND  = 4'b0000,
    ALUCTL_OR   = 4'b0001,
    ALUCTL_ADD  = 4'b0010,
    ALUCTL_XOR  = 4'b0011,
    ALUCTL_SLL  = 4'b0100,
    ALUCTL_SRL  = 4'b0101,
    ALUCTL_SUB  = 4'b0110,
    ALUCTL_SLT  = 4'b0111,
    ALUCTL_SRA  = 4'b1000,
    ALUCTL_SLTU = 4'b1001,
    ALUCTL_LUI  = 4'b1010,
    ALUCTL_NOR  = 4'b1100,
    ALUCTL_ZERO = 4'b1111
  } alu_ctl_e;

  // Control vector layout, bit 8 (RegDst) down to bit 0 (BranchNe)
  localparam int CTRL_W = 9;
  typedef logic [CTRL_W-1:0] ctrl_t;

  localparam int CTRL_REGDST_IDX   = 8;
  localparam int CTRL_BRANCHEQ_IDX = 7;
  localparam int CTRL_MEMREAD_IDX  = 6;
  localparam int CTRL_MEMTOREG_IDX = 5;
  localparam int CTRL_MEMWRITE_IDX = 4;
  localparam int CTRL_ALUSRC_IDX   = 3;
  localparam int CTRL_REGWRITE_IDX = 2;
  localparam int CTRL_EXTSIGN_IDX  = 1;
  localparam int CTRL_BRANCHNE_IDX = 0;

  // One-hot masks so decode entries read as an OR of named flags
  localparam ctrl_t C_REGDST   = ctrl_t'(1) << CTRL_REGDST_IDX;
  localparam ctrl_t C_BRANCHEQ = ctrl_t'(1) << CTRL_BRANCHEQ_IDX;
  localparam ctrl_t C_MEMREAD  = ctrl_t'(1) << CTRL_MEMREAD_IDX;
  localparam ctrl_t C_MEMTOREG = ctrl_t'(1) << CTRL_MEMTOREG_IDX;
  localparam ctrl_t C_MEMWRITE = ctrl_t'(1) << CTRL_MEMWRITE_IDX;
  localparam ctrl_t C_ALUSRC   = ctrl_t'(1) << CTRL_ALUSRC_IDX;
  localparam ctrl_t C_REGWRITE = ctrl_t'(1) << CTRL_REGWRITE_IDX;
  localparam ctrl_t C_EXTSIGN  = ctrl_t'(1) << CTRL_EXTSIGN_IDX;
  localparam ctrl_t C_BRANCHNE = ctrl_t'(1) << CTRL_BRANCHNE_IDX;

endpackage

// File: rtl/mips_alu_core.sv
// Purpose: combinational 32-bit MIPS ALU (A, B, ALUCtl, shamt -> result, zero, ovf).
// Latency: 0 cycles (pure combinational). Backpressure: none, no handshake.
// Ports: a_i/b_i operands, alu_ctl_i operation, shamt_i shift amount applied to B,
//        result_o, zero_o (result == 0), ovf_o (signed ADD/SUB overflow).
// Build option ALU_OVERFLOW_DETECT_EN: when defined ovf_o reports signed
// overflow of ADD/SUB; otherwise ovf_o is tied 0 and no detection logic exists.
module mips_alu_core
  import mips_decode_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  alu_ctl_e          alu_ctl_i,
  input  logic [4:0]        shamt_i,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o,
  output logic              ovf_o
);

  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;

  // Both wrap modulo 2^DATA_W
  assign sum  = a_i + b_i;
  assign diff = a_i - b_i;

  always_comb begin
    result_o = '0;
    case (alu_ctl_i)
      ALUCTL_AND:  result_o = a_i & b_i;
      ALUCTL_OR:   result_o = a_i | b_i;
      ALUCTL_ADD:  result_o = sum;
      ALUCTL_XOR:  result_o = a_i ^ b_i;
      ALUCTL_NOR:  result_o = ~(a_i | b_i);
      ALUCTL_SUB:  result_o = diff;
      // Shifts operate on B (the rt operand) by the instruction's shamt field
      ALUCTL_SLL:  result_o = b_i << shamt_i;
      ALUCTL_SRL:  result_o = b_i >> shamt_i;
      ALUCTL_SRA:  result_o = $unsigned($signed(b_i) >>> shamt_i);
      ALUCTL_SLT:  result_o = {{(DATA_W-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      ALUCTL_SLTU: result_o = {{(DATA_W-1){1'b0}}, (a_i < b_i)};
      // B carries the zero-extended immediate for lui
      ALUCTL_LUI:  result_o = {b_i[15:0], 16'h0000};
      default:     result_o = '0;
    endcase
  end

  assign zero_o = (result_o == '0);

`ifdef ALU_OVERFLOW_DETECT_EN
  // Signed overflow: add of like-signed operands, or subtract of unlike-signed
  // operands, producing a result whose sign differs from A.
  always_comb begin
    ovf_o = 1'b0;
    if (alu_ctl_i == ALUCTL_ADD) begin
      ovf_o = (a_i[DATA_W-1] == b_i[DATA_W-1]) && (sum[DATA_W-1] != a_i[DATA_W-1]);
    end else if (alu_ctl_i == ALUCTL_SUB) begin
      ovf_o = (a_i[DATA_W-1] != b_i[DATA_W-1]) && (diff[DATA_W-1] != a_i[DATA_W-1]);
    end
  end
`else
  assign ovf_o = 1'b0;
`endif

endmodule

// File: rtl/mips_decode_alu_stage.sv
// Purpose: MIPS decode + execute slice: main decode, ALU-control decode,
//          immediate extend, ALUSrc mux and ALU, all outputs registered once.
// Latency: 1 cycle (inputs sampled and outputs updated on the same rising edge).
// Backpressure: none; a new instruction may be accepted every cycle.
// Ports: clock, reset (async, active-low); valid_i/instr_i/rs_data_i/rt_data_i in;
//        valid_o, alu_res_o, zero_o, ovf_o, ctrl_o (9b, bit8=RegDst .. bit0=BranchNe),
//        alu_op_o, alu_ctl_o, store_o (registered rt_data_i) out.
// Build option ALU_OVERFLOW_DETECT_EN enables signed-overflow reporting on ovf_o.
// DATA_W must be 32.
module mips_decode_alu_stage
  import mips_decode_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              valid_i,
  input  logic [31:0]       instr_i,
  input  logic [DATA_W-1:0] rs_data_i,
  input  logic [DATA_W-1:0] rt_data_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] alu_res_o,
  output logic              zero_o,
  output logic              ovf_o,
  output logic [8:0]        ctrl_o,
  output logic [2:0]        alu_op_o,
  output logic [3:0]        alu_ctl_o,
  output logic [DATA_W-1:0] store_o
);

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [15:0] imm;

  assign opcode = instr_i[31:26];
  assign funct  = instr_i[5:0];
  assign shamt  = instr_i[10:6];
  assign imm    = instr_i[15:0];

  // Register specifiers are consumed by the register file, not here
  logic unused_instr_bits;
  assign unused_instr_bits = ^instr_i[25:16];

  // ---------------------------------------------------------------- main decode
  ctrl_t   ctrl_dec;
  alu_op_e alu_op;

  always_comb begin
    ctrl_dec = '0;
    alu_op   = ALUOP_ZERO;
    case (opcode)
      OP_RTYPE: begin
        ctrl_dec = C_REGDST | C_REGWRITE;
        alu_op   = ALUOP_RTYPE;
      end
      OP_LW: begin
        ctrl_dec = C_MEMREAD | C_MEMTOREG | C_ALUSRC | C_REGWRITE | C_EXTSIGN;
        alu_op   = ALUOP_ADD;
      end
      OP_SW: begin
        ctrl_dec = C_MEMWRITE | C_ALUSRC | C_EXTSIGN;
        alu_op   = ALUOP_ADD;
      end
      OP_BEQ: begin
        ctrl_dec = C_BRANCHEQ | C_EXTSIGN;
        alu_op   = ALUOP_SUB;
      end
      OP_BNE: begin
        ctrl_dec = C_BRANCHNE | C_EXTSIGN;
        alu_op   = ALUOP_SUB;
      end
      OP_ADDI, OP_ADDIU: begin
        ctrl_dec = C_ALUSRC | C_REGWRITE | C_EXTSIGN;
        alu_op   = ALUOP_ADD;
      end
      OP_ANDI: begin
        ctrl_dec = C_ALUSRC | C_REGWRITE;
        alu_op   = ALUOP_AND;
      end
      OP_ORI: begin
        ctrl_dec = C_ALUSRC | C_REGWRITE;
        alu_op   = ALUOP_OR;
      end
      OP_SLTI: begin
        ctrl_dec = C_ALUSRC | C_REGWRITE | C_EXTSIGN;
        alu_op   = ALUOP_SLT;
      end
      OP_LUI: begin
        ctrl_dec = C_ALUSRC | C_REGWRITE;
        alu_op   = ALUOP_LUI;
      end
      // Unknown opcodes become a harmless no-op producing 0
      default: begin
        ctrl_dec = '0;
        alu_op   = ALUOP_ZERO;
      end
    endcase
  end

  // ---------------------------------------------------------------- ALU control
  alu_ctl_e alu_ctl;

  always_comb begin
    alu_ctl = ALUCTL_ZERO;
    case (alu_op)
      ALUOP_ADD:  alu_ctl = ALUCTL_ADD;
      ALUOP_SUB:  alu_ctl = ALUCTL_SUB;
      ALUOP_AND:  alu_ctl = ALUCTL_AND;
      ALUOP_OR:   alu_ctl = ALUCTL_OR;
      ALUOP_SLT:  alu_ctl = ALUCTL_SLT;
      ALUOP_LUI:  alu_ctl = ALUCTL_LUI;
      ALUOP_ZERO: alu_ctl = ALUCTL_ZERO;
      ALUOP_RTYPE: begin
        case (funct)
          FN_ADD, FN_ADDU: alu_ctl = ALUCTL_ADD;
          FN_SUB, FN_SUBU: alu_ctl = ALUCTL_SUB;
          FN_AND:          alu_ctl = ALUCTL_AND;
          FN_OR:           alu_ctl = ALUCTL_OR;
          FN_XOR:          alu_ctl = ALUCTL_XOR;
          FN_NOR:          alu_ctl = ALUCTL_NOR;
          FN_SLT:          alu_ctl = ALUCTL_SLT;
          FN_SLTU:         alu_ctl = ALUCTL_SLTU;
          FN_SLL:          alu_ctl = ALUCTL_SLL;
          FN_SRL:          alu_ctl = ALUCTL_SRL;
          FN_SRA:          alu_ctl = ALUCTL_SRA;
          default:         alu_ctl = ALUCTL_ZERO;
        endcase
      end
      default: alu_ctl = ALUCTL_ZERO;
    endcase
  end

  // ---------------------------------------------------------------- operand B
  logic              ext_sign;
  logic              alu_src;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] alu_b;

  assign ext_sign = ctrl_dec[CTRL_EXTSIGN_IDX];
  assign alu_src  = ctrl_dec[CTRL_ALUSRC_IDX];
  assign imm_ext  = ext_sign ? {{(DATA_W-16){imm[15]}}, imm} : {{(DATA_W-16){1'b0}}, imm};
  assign alu_b    = alu_src ? imm_ext : rt_data_i;

  // ---------------------------------------------------------------- ALU
  logic [DATA_W-1:0] alu_res;
  logic              alu_zero;
  logic              alu_ovf;

  mips_alu_core #(
    .DATA_W (DATA_W)
  ) u_alu (
    .a_i       (rs_data_i),
    .b_i       (alu_b),
    .alu_ctl_i (alu_ctl),
    .shamt_i   (shamt),
    .result_o  (alu_res),
    .zero_o    (alu_zero),
    .ovf_o     (alu_ovf)
  );

  // ---------------------------------------------------------------- output registers
  logic              valid_d,   valid_q;
  logic [DATA_W-1:0] alu_res_d, alu_res_q;
  logic              zero_d,    zero_q;
  logic              ovf_d,     ovf_q;
  logic [8:0]        ctrl_d,    ctrl_q;
  logic [2:0]        alu_op_d,  alu_op_q;
  logic [3:0]        alu_ctl_d, alu_ctl_q;
  logic [DATA_W-1:0] store_d,   store_q;

  always_comb begin
    valid_d   = valid_i;
    alu_res_d = alu_res;
    zero_d    = alu_zero;
    ovf_d     = alu_ovf;
    // A bubble must not trigger register/memory writes or branches downstream
    ctrl_d    = valid_i ? ctrl_dec : '0;
    alu_op_d  = alu_op;
    alu_ctl_d = alu_ctl;
    store_d   = rt_data_i;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q   <= 1'b0;
      alu_res_q <= '0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
      ctrl_q    <= '0;
      alu_op_q  <= '0;
      alu_ctl_q <= '0;
      store_q   <= '0;
    end else begin
      valid_q   <= valid_d;
      alu_res_q <= alu_res_d;
      zero_q    <= zero_d;
      ovf_q     <= ovf_d;
      ctrl_q    <= ctrl_d;
      alu_op_q  <= alu_op_d;
      alu_ctl_q <= alu_ctl_d;
      store_q   <= store_d;
    end
  end

  assign valid_o   = valid_q;
  assign alu_res_o = alu_res_q;
  assign zero_o    = zero_q;
  assign ovf_o     = ovf_q;
  assign ctrl_o    = ctrl_q;
  assign alu_op_o  = alu_op_q;
  assign alu_ctl_o = alu_ctl_q;
  assign store_o   = store_q;

endmodule

// File: tb/tb_mips_decode_alu_stage.sv
// Directed bench for mips_decode_alu_stage: each step drives one instruction,
// queues the hand-derived expected outputs, and compares after the next edge.
module tb_mips_decode_alu_stage;

  logic        clock;
  logic        reset;
  logic        valid_i;
  logic [31:0] instr_i;
  logic [31:0] rs_data_i;
  logic [31:0] rt_data_i;
  logic        valid_o;
  logic [31:0] alu_res_o;
  logic        zero_o;
  logic        ovf_o;
  logic [8:0]  ctrl_o;
  logic [2:0]  alu_op_o;
  logic [3:0]  alu_ctl_o;
  logic [31:0] store_o;

  mips_decode_alu_stage #(.DATA_W(32)) dut (
    .clock     (clock),
    .reset     (reset),
    .valid_i   (valid_i),
    .instr_i   (instr_i),
    .rs_data_i (rs_data_i),
    .rt_data_i (rt_data_i),
    .valid_o   (valid_o),
    .alu_res_o (alu_res_o),
    .zero_o    (zero_o),
    .ovf_o     (ovf_o),
    .ctrl_o    (ctrl_o),
    .alu_op_o  (alu_op_o),
    .alu_ctl_o (alu_ctl_o),
    .store_o   (store_o)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

`ifdef ALU_OVERFLOW_DETECT_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  typedef struct {
    logic        v;
    logic [31:0] res;
    logic        z;
    logic        ov;
    logic [8:0]  ctrl;
    logic [2:0]  op;
    logic [3:0]  ctl;
    logic [31:0] st;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'b000000, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic chk(input string tag, input string fld, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input exp_t e);
    chk(tag, "valid",   32'(valid_o),   32'(e.v));
    chk(tag, "alu_res", alu_res_o,      e.res);
    chk(tag, "zero",    32'(zero_o),    32'(e.z));
    chk(tag, "ovf",     32'(ovf_o),     32'(e.ov));
    chk(tag, "ctrl",    32'(ctrl_o),    32'(e.ctrl));
    chk(tag, "alu_op",  32'(alu_op_o),  32'(e.op));
    chk(tag, "alu_ctl", 32'(alu_ctl_o), 32'(e.ctl));
    chk(tag, "store",   store_o,        e.st);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    total++;
    assert (sb.size() != 0) else begin
      bad++;
      $error("FAIL %s.scoreboard observed=empty expected=entry", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check_all(tag, e);
    end
  endtask

  // Drive one instruction at the falling edge, queue its expectation, and
  // compare just after the rising edge that registers it.
  task automatic run(input string tag, input logic v, input logic [31:0] ins,
                     input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] res,
                     input logic ov, input logic [8:0] ctrl, input logic [2:0] op,
                     input logic [3:0] ctl);
    exp_t e;
    @(negedge clock);
    valid_i   = v;
    instr_i   = ins;
    rs_data_i = rs;
    rt_data_i = rt;
    e.v    = v;
    e.res  = res;
    e.z    = (res == 32'h0);
    e.ov   = ov;
    e.ctrl = v ? ctrl : 9'h000;
    e.op   = op;
    e.ctl  = ctl;
    e.st   = rt;
    sb.push_back(e);
    @(posedge clock);
    #1;
    pop_check(tag);
  endtask

  exp_t zero_e;

  initial begin
    zero_e = '{v: 1'b0, res: 32'h0, z: 1'b0, ov: 1'b0, ctrl: 9'h0, op: 3'h0, ctl: 4'h0, st: 32'h0};
    reset     = 1'b0;
    valid_i   = 1'b0;
    instr_i   = 32'h0;
    rs_data_i = 32'h0;
    rt_data_i = 32'h0;
    repeat (2) @(posedge clock);
    #1;
    sb.push_back(zero_e);
    pop_check("reset_state");
    @(negedge clock);
    reset = 1'b1;

    //   tag          v     instr                              rs            rt            result        ovf     ctrl    op      ctl
    run("r_add",     1'b1, 32'h00221820,                      32'd5,        32'd7,        32'd12,       1'b0,   9'h104, 3'b010, 4'h2);
    run("beq_eq",    1'b1, i_ins(6'h04, 5'd1, 5'd2, 16'h0010), 32'h1234,     32'h1234,     32'h0,        1'b0,   9'h082, 3'b001, 4'h6);
    run("bne_ne",    1'b1, i_ins(6'h05, 5'd1, 5'd2, 16'h0010), 32'd1,        32'd2,        32'hFFFFFFFF, 1'b0,   9'h003, 3'b001, 4'h6);
    run("lw",        1'b1, i_ins(6'h23, 5'd1, 5'd2, 16'hFFFC), 32'h100,      32'hDEAD,     32'h000000FC, 1'b0,   9'h06E, 3'b000, 4'h2);
    run("sw",        1'b1, i_ins(6'h2B, 5'd1, 5'd2, 16'h0008), 32'h1000,     32'hCAFE,     32'h00001008, 1'b0,   9'h01A, 3'b000, 4'h2);
    run("ori",       1'b1, i_ins(6'h0D, 5'd0, 5'd2, 16'h8000), 32'h0,        32'h3,        32'h00008000, 1'b0,   9'h00C, 3'b100, 4'h1);
    run("andi",      1'b1, i_ins(6'h0C, 5'd1, 5'd2, 16'hFF00), 32'hFFFF1234, 32'h0,        32'h00001200, 1'b0,   9'h00C, 3'b011, 4'h0);
    run("addi_neg",  1'b1, i_ins(6'h08, 5'd1, 5'd2, 16'hFFFF), 32'd1,        32'h9,        32'h0,        1'b0,   9'h00E, 3'b000, 4'h2);
    run("slti",      1'b1, i_ins(6'h0A, 5'd1, 5'd2, 16'hFFFF), 32'd5,        32'h0,        32'h0,        1'b0,   9'h00E, 3'b101, 4'h7);
    run("lui",       1'b1, i_ins(6'h0F, 5'd0, 5'd2, 16'h1234), 32'h77,       32'h0,        32'h12340000, 1'b0,   9'h00C, 3'b111, 4'hA);
    run("sra",       1'b1, r_ins(5'd1, 5'd2, 5'd3, 5'd4, 6'h03), 32'h55,     32'h80000000, 32'hF8000000, 1'b0,   9'h104, 3'b010, 4'h8);
    run("srl",       1'b1, r_ins(5'd1, 5'd2, 5'd3, 5'd4, 6'h02), 32'h55,     32'h80000000, 32'h08000000, 1'b0,   9'h104, 3'b010, 4'h5);
    run("sll",       1'b1, r_ins(5'd1, 5'd2, 5'd3, 5'd8, 6'h00), 32'h55,     32'h1,        32'h00000100, 1'b0,   9'h104, 3'b010, 4'h4);
    run("slt",       1'b1, r_ins(5'd1, 5'd2, 5'd3, 5'd0, 6'h2A), 32'hFFFFFFFF, 32'd1,      32'd1,        1'b0,   9'h104, 3'b010, 4'h7);
    run("sltu",      1'b1, r_ins(5'd1, 5'd2, 5'd3, 5'd0, 6'h2B), 32'hFFFFFFFF, 32'd1,      32'd0,        1'b0,   9'h104, 3'b010, 4'h9);
    run("xor",       1'b1, r_ins(5'd1, 5'd2, 5'd3, 5'd0, 6'h26), 32'hF0F0,   32'hFF00,     32'h00000FF0, 1'b0,   9'h104, 3'b010, 4'h3);
    run("nor",       1'b1, r_ins(5'd1, 5'd2, 5'd3, 5'd0, 6'h27), 32'h0,      32'h0,        32'hFFFFFFFF, 1'b0,   9'h104, 3'b010, 4'hC);
    run("subu",      1'b1, r_ins(5'd1, 5'd2, 5'd3, 5'd0, 6'h23), 32'd10,     32'd3,        32'd7,        1'b0,   9'h104, 3'b010, 4'h6);
    run("bad_funct", 1'b1, r_ins(5'd1, 5'd2, 5'd3, 5'd0, 6'h3F), 32'd10,     32'd3,        32'd0,        1'b0,   9'h104, 3'b010, 4'hF);
    run("add_ovf",   1'b1, r_ins(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 32'h7FFFFFFF, 32'd1,      32'h80000000, OVF_ON, 9'h104, 3'b010, 4'h2);
    run("bne_ovf",   1'b1, i_ins(6'h05, 5'd1, 5'd2, 16'h0004), 32'h80000000, 32'd1,        32'h7FFFFFFF, OVF_ON, 9'h003, 3'b001, 4'h6);
    run("bad_op",    1'b1, i_ins(6'h3F, 5'd1, 5'd2, 16'h1234), 32'h55,       32'h66,       32'h0,        1'b0,   9'h000, 3'b110, 4'hF);
    run("bubble",    1'b0, 32'h00221820,                      32'd5,        32'd7,        32'd12,       1'b0,   9'h104, 3'b010, 4'h2);
    run("pre_rst",   1'b1, i_ins(6'h23, 5'd1, 5'd2, 16'h0004), 32'h200,      32'hBEEF,     32'h00000204, 1'b0,   9'h06E, 3'b000, 4'h2);

    // Reset asserted between edges must clear outputs without waiting for a clock
    #2;
    reset = 1'b0;
    #1;
    sb.push_back(zero_e);
    pop_check("async_rst");
    @(negedge clock);
    reset = 1'b1;

    run("post_rst",  1'b1, 32'h00221820,                      32'd20,       32'd22,       32'd42,       1'b0,   9'h104, 3'b010, 4'h2);

    chk("final", "sb_left", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
